// File: rtl/key_lut_table.sv
// Small fully-associative key -> data lookup table with a one-deep registered
// response stage, optional miss default, OR-merge or priority hit resolution and hit/miss statistics.
module key_lut_table #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter bit HAS_DEFAULT = 1'b0,
    parameter bit PRIORITY    = 1'b0,
    parameter int CNT_LEN     = 16,
    localparam int IDX_LEN    = (NR_KEY <= 2) ? 1 : $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic                rsp_multi,
    output logic [CNT_LEN-1:0]  hit_cnt,
    output logic [CNT_LEN-1:0]  miss_cnt
);

    logic [NR_KEY-1:0]   valid_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    logic                accept;
    logic                look_hit;
    logic                look_multi;
    logic [DATA_LEN-1:0] or_data;
    logic [DATA_LEN-1:0] pri_data;
    logic [DATA_LEN-1:0] look_data;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Match against the registered table, so a same-edge write or clr is not yet visible.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        look_hit   = 1'b0;
        look_multi = 1'b0;
        or_data    = '0;
        pri_data   = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (valid_q[i] && (key_q[i] == req_key)) begin
                or_data = or_data | data_q[i];
                if (look_hit) begin
                    look_multi = 1'b1;
                end else begin
                    pri_data = data_q[i];
                    look_hit = 1'b1;
                end
            end
        end
        if (look_hit)
            look_data = PRIORITY ? pri_data : or_data;
        else
            look_data = HAS_DEFAULT ? default_out : '0;
    end

    // NOTE: key/data storage is deliberately left unreset; the valid bits alone gate matching.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_KEY; i++) begin
            if (wr_en && (wr_idx == IDX_LEN'(i))) begin
                key_q[i]  <= wr_key;
                data_q[i] <= wr_data;
            end
        end
    end

    // Indices at or beyond NR_KEY match no entry, so such writes fall through untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_en && (wr_idx == IDX_LEN'(i)))
                    valid_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= look_data;
            rsp_hit   <= look_hit;
            rsp_multi <= look_multi;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Counters stick at all-ones; clr never touches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (look_hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_LEN'(1);
            if (!look_hit && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_LEN'(1);
        end
    end

endmodule

// File: tb/tb_key_lut_table.sv
// Directed bench for key_lut_table: three instances (OR-merge with default, priority with
// 2-bit counters, 3-entry table) share one stimulus stream and are compared to hand values.
module tb_key_lut_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [3:0] wr_key = '0;
    logic [7:0] wr_data = '0;
    logic       clr = 1'b0;
    logic [7:0] default_out = 8'h5A;
    logic       req_valid = 1'b0;
    logic [3:0] req_key = '0;
    logic       rsp_ready = 1'b1;

    logic        m_req_ready, m_rsp_valid, m_rsp_hit, m_rsp_multi;
    logic [7:0]  m_rsp_data;
    logic [15:0] m_hit_cnt, m_miss_cnt;

    logic        p_req_ready, p_rsp_valid, p_rsp_hit, p_rsp_multi;
    logic [7:0]  p_rsp_data;
    logic [1:0]  p_hit_cnt, p_miss_cnt;

    logic        r_req_ready, r_rsp_valid, r_rsp_hit, r_rsp_multi;
    logic [7:0]  r_rsp_data;
    logic [15:0] r_hit_cnt, r_miss_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    key_lut_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b1),
                    .PRIORITY(1'b0), .CNT_LEN(16)) u_main (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr(clr), .default_out(default_out),
        .req_valid(req_valid), .req_ready(m_req_ready), .req_key(req_key),
        .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(m_rsp_data),
        .rsp_hit(m_rsp_hit), .rsp_multi(m_rsp_multi),
        .hit_cnt(m_hit_cnt), .miss_cnt(m_miss_cnt));

    key_lut_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b0),
                    .PRIORITY(1'b1), .CNT_LEN(2)) u_pri (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr(clr), .default_out(default_out),
        .req_valid(req_valid), .req_ready(p_req_ready), .req_key(req_key),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(p_rsp_data),
        .rsp_hit(p_rsp_hit), .rsp_multi(p_rsp_multi),
        .hit_cnt(p_hit_cnt), .miss_cnt(p_miss_cnt));

    key_lut_table #(.NR_KEY(3), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b0),
                    .PRIORITY(1'b0), .CNT_LEN(16)) u_rng (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr(clr), .default_out(default_out),
        .req_valid(req_valid), .req_ready(r_req_ready), .req_key(req_key),
        .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r_rsp_data),
        .rsp_hit(r_rsp_hit), .rsp_multi(r_rsp_multi),
        .hit_cnt(r_hit_cnt), .miss_cnt(r_miss_cnt));

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_idx;
        logic [3:0] wr_key;
        logic [7:0] wr_data;
        logic       clr;
        logic       req_valid;
        logic [3:0] req_key;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_hit;
        logic       exp_multi;
        logic [7:0] exp_pri;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr  idx key  data   clr rv  rkey  ev  edata  eh  em  epri
        vecs[0]  = '{1, 0, 3, 8'hA5, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00};
        vecs[1]  = '{0, 0, 0, 8'h00, 0, 1, 3,   1, 8'hA5, 1, 0, 8'hA5};
        vecs[2]  = '{0, 0, 0, 8'h00, 0, 1, 7,   1, 8'h5A, 0, 0, 8'h00};
        vecs[3]  = '{1, 1, 9, 8'h0F, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00};
        vecs[4]  = '{1, 2, 9, 8'hF0, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00};
        vecs[5]  = '{0, 0, 0, 8'h00, 0, 1, 9,   1, 8'hFF, 1, 1, 8'h0F};
        vecs[6]  = '{1, 0, 3, 8'h11, 0, 1, 3,   1, 8'hA5, 1, 0, 8'hA5};
        vecs[7]  = '{0, 0, 0, 8'h00, 0, 1, 3,   1, 8'h11, 1, 0, 8'h11};
        vecs[8]  = '{1, 0, 3, 8'h22, 1, 0, 0,   0, 8'h00, 0, 0, 8'h00};
        vecs[9]  = '{0, 0, 0, 8'h00, 0, 1, 3,   1, 8'h5A, 0, 0, 8'h00};
        vecs[10] = '{0, 0, 0, 8'h00, 0, 1, 9,   1, 8'h5A, 0, 0, 8'h00};

        // Reset state, then release between edges.
        #12;
        check("reset rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("reset rsp_data", 32'(m_rsp_data), 32'd0);
        check("reset hit_cnt", 32'(m_hit_cnt), 32'd0);
        check("reset miss_cnt", 32'(m_miss_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset req_ready", 32'(m_req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            wr_en     = vecs[i].wr_en;
            wr_idx    = vecs[i].wr_idx;
            wr_key    = vecs[i].wr_key;
            wr_data   = vecs[i].wr_data;
            clr       = vecs[i].clr;
            req_valid = vecs[i].req_valid;
            req_key   = vecs[i].req_key;
            rsp_ready = 1'b1;
            step();
            check($sformatf("v%0d rsp_valid", i), 32'(m_rsp_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d rsp_data", i), 32'(m_rsp_data), 32'(vecs[i].exp_data));
                check($sformatf("v%0d rsp_hit", i), 32'(m_rsp_hit), 32'(vecs[i].exp_hit));
                check($sformatf("v%0d rsp_multi", i), 32'(m_rsp_multi), 32'(vecs[i].exp_multi));
                check($sformatf("v%0d pri rsp_data", i), 32'(p_rsp_data), 32'(vecs[i].exp_pri));
                check($sformatf("v%0d pri rsp_multi", i), 32'(p_rsp_multi), 32'(vecs[i].exp_multi));
            end
        end
        wr_en = 1'b0; clr = 1'b0; req_valid = 1'b0;
        check("counters kept over clr: hit", 32'(m_hit_cnt), 32'd4);
        check("counters kept over clr: miss", 32'(m_miss_cnt), 32'd3);

        // Out-of-range write: only the 4-entry table gains key 3.
        wr_en = 1'b1; wr_idx = 2'd3; wr_key = 4'd3; wr_data = 8'h77;
        step();
        wr_en = 1'b0; req_valid = 1'b1; req_key = 4'd3;
        step();
        check("range main rsp_data", 32'(m_rsp_data), 32'h77);
        check("range main rsp_hit", 32'(m_rsp_hit), 32'd1);
        check("range 3-entry rsp_hit", 32'(r_rsp_hit), 32'd0);
        check("range 3-entry rsp_data", 32'(r_rsp_data), 32'd0);

        // Drain, then backpressure with a steady request.
        req_valid = 1'b0;
        step();
        check("drain rsp_valid", 32'(m_rsp_valid), 32'd0);
        req_valid = 1'b1; req_key = 4'd3; rsp_ready = 1'b0;
        step();
        check("bp first rsp_data", 32'(m_rsp_data), 32'h77);
        check("bp first req_ready", 32'(m_req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp%0d rsp_valid", c), 32'(m_rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_data", c), 32'(m_rsp_data), 32'h77);
            check($sformatf("bp%0d req_ready", c), 32'(m_req_ready), 32'd0);
            check($sformatf("bp%0d hit_cnt", c), 32'(m_hit_cnt), 32'd6);
        end

        // Release: one response per cycle.
        rsp_ready = 1'b1; req_key = 4'd9;
        #1;
        check("release req_ready", 32'(m_req_ready), 32'd1);
        step();
        check("b2b0 rsp_data", 32'(m_rsp_data), 32'h5A);
        check("b2b0 rsp_hit", 32'(m_rsp_hit), 32'd0);
        req_key = 4'd3;
        step();
        check("b2b1 rsp_data", 32'(m_rsp_data), 32'h77);
        check("b2b1 rsp_valid", 32'(m_rsp_valid), 32'd1);
        req_key = 4'd9;
        step();
        check("b2b2 rsp_data", 32'(m_rsp_data), 32'h5A);
        check("b2b2 req_ready", 32'(m_req_ready), 32'd1);

        check("main hit_cnt", 32'(m_hit_cnt), 32'd7);
        check("main miss_cnt", 32'(m_miss_cnt), 32'd5);
        check("sat hit_cnt", 32'(p_hit_cnt), 32'd3);
        check("sat miss_cnt", 32'(p_miss_cnt), 32'd3);
        check("3-entry hit_cnt", 32'(r_hit_cnt), 32'd4);
        check("3-entry miss_cnt", 32'(r_miss_cnt), 32'd8);

        // Asynchronous reset while a response is held.
        req_valid = 1'b0; rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("async rst rsp_data", 32'(m_rsp_data), 32'd0);
        check("async rst rsp_hit", 32'(m_rsp_hit), 32'd0);
        check("async rst hit_cnt", 32'(m_hit_cnt), 32'd0);
        check("async rst miss_cnt", 32'(m_miss_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("after rst req_ready", 32'(m_req_ready), 32'd1);
        req_valid = 1'b1; req_key = 4'd3; rsp_ready = 1'b1;
        step();
        check("after rst lookup misses", 32'(m_rsp_hit), 32'd0);
        check("after rst miss_cnt", 32'(m_miss_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
